// File: rtl/aes_sched_pkg.sv
// Shared widths, counter-block layout and FSM encoding for the AES-CTR scheduler.
// Latency: none (types and constants only).
// Backpressure: none.
package aes_sched_pkg;

    localparam int CTR_W   = 32;
    localparam int BLK_W   = 128;
    localparam int KIDX_W  = 4;
    localparam int NONCE_W = BLK_W - CTR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    // Counter block as presented to the cipher pipeline: nonce in the upper bits.
    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [CTR_W-1:0]   ctr;
    } ctr_blk_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// First-word fall-through FIFO holding cipher results until the consumer takes them.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none on push (caller reserves space); pop on an empty FIFO is ignored.
module aes_sched_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on push and on a pop of a non-empty FIFO.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/aes_ctr_sched.sv
// AES-CTR scheduler: round-key file, counter-block issue to an external cipher pipeline, keystream buffer.
// Latency: first issue the cycle after start; keystream word one cycle after the matching pipe_ready.
// Backpressure: issue throttled so in-flight plus buffered never exceeds FIFO_DEPTH; out_ready stalls the buffer.
// Build option: AES_SCHED_WRAP_ERR_EN makes a 32-bit counter wrap end the stream and raise sticky err.
module aes_ctr_sched
    import aes_sched_pkg::*;
#(
    parameter int ROUNDS     = 10,
    parameter int PIPE_LAT   = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rk_we,
    input  logic [KIDX_W-1:0]  rk_idx,
    input  logic [BLK_W-1:0]   rk_data,
    input  logic               start,
    input  logic               stop,
    input  logic [NONCE_W-1:0] nonce,
    input  logic [CTR_W-1:0]   ctr_init,
    input  logic [CTR_W-1:0]   nblocks,
    input  logic [KIDX_W-1:0]  pipe_round,
    output logic [BLK_W-1:0]   pipe_round_key,
    output logic [BLK_W-1:0]   pipe_block,
    output logic               pipe_next,
    input  logic               pipe_ready,
    input  logic [BLK_W-1:0]   pipe_new_block,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLK_W-1:0]   out_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [KIDX_W-1:0] MAX_IDX = KIDX_W'(ROUNDS);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]    OCC_LIM = (CNT_W+1)'(FIFO_DEPTH);

    // The buffer must absorb a full pipeline's worth of results, so it has to be deeper than the latency.
    if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH <= PIPE_LAT) || (ROUNDS > 15)) begin : g_bad_cfg
        $error("aes_ctr_sched: FIFO_DEPTH must be a power of 2 above PIPE_LAT and ROUNDS must be <= 15");
    end

    sched_state_e       state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [CTR_W-1:0]   rem_q, rem_d;
    logic               unb_q, unb_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               done_q, done_d;
    logic [BLK_W-1:0]   rk_q [ROUNDS+1];

    logic               issue;
    logic               accept;
    logic               room;
    logic               pop;
    logic [CNT_W:0]     occ;
    logic [BLK_W-1:0]   fifo_head;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;
    ctr_blk_t           blk;

    // Round-key file: writable only while idle so a running stream sees a stable schedule.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= ROUNDS; i++) rk_q[i] <= '0;
        end else if (rk_we && (state_q == ST_IDLE) && (rk_idx <= MAX_IDX)) begin
            rk_q[rk_idx] <= rk_data;
        end
    end

    assign pipe_round_key = (pipe_round <= MAX_IDX) ? rk_q[pipe_round] : '0;

    // Only results matching an outstanding issue are accepted; stray pulses after reset are dropped.
    assign accept = pipe_ready && (state_q != ST_IDLE) && (inflight_q != '0);
    assign occ    = {1'b0, inflight_q} + {1'b0, fifo_cnt};
    assign room   = (occ < OCC_LIM);

    // Stream FSM and counter/remaining-count bookkeeping.
    always_comb begin
        state_d = state_q;
        nonce_d = nonce_q;
        ctr_d   = ctr_q;
        rem_d   = rem_q;
        unb_d   = unb_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    nonce_d = nonce;
                    ctr_d   = ctr_init;
                    rem_d   = nblocks;
                    unb_d   = (nblocks == '0);
                end
            end
            ST_RUN: begin
                issue = room && (unb_q || (rem_q != '0));
                if (issue) begin
                    ctr_d = ctr_q + 32'd1;
                    if (!unb_q) rem_d = rem_q - 32'd1;
                end
                if (stop) begin
                    state_d = ST_DRAIN;
                end else if (issue && !unb_q && (rem_q == 32'd1)) begin
                    state_d = ST_DRAIN;
                end
`ifdef AES_SCHED_WRAP_ERR_EN
                if (issue && (ctr_q == '1)) state_d = ST_DRAIN;
`endif
            end
            ST_DRAIN: begin
                if ((inflight_q == '0) && fifo_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // In-flight count: simultaneous issue and accept cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (issue && !accept) begin
            inflight_d = inflight_q + CNT_ONE;
        end else if (!issue && accept) begin
            inflight_d = inflight_q - CNT_ONE;
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            nonce_q    <= '0;
            ctr_q      <= '0;
            rem_q      <= '0;
            unb_q      <= 1'b0;
            inflight_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nonce_q    <= nonce_d;
            ctr_q      <= ctr_d;
            rem_q      <= rem_d;
            unb_q      <= unb_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

`ifdef AES_SCHED_WRAP_ERR_EN
    logic err_q, err_d;

    // Sticky wrap flag, cleared only by the next accepted start.
    always_comb begin
        err_d = err_q;
        if ((state_q == ST_IDLE) && start) begin
            err_d = 1'b0;
        end else if (issue && (ctr_q == '1)) begin
            err_d = 1'b1;
        end
    end

    // Wrap flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    aes_sched_fifo #(
        .WIDTH (BLK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (accept),
        .push_dat_i (pipe_new_block),
        .pop_i      (pop),
        .pop_dat_o  (fifo_head),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    assign blk.nonce  = nonce_q;
    assign blk.ctr    = ctr_q;
    assign pipe_block = blk;
    assign pipe_next  = issue;
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : fifo_head;
    assign pop        = out_valid && out_ready;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

endmodule

// File: doc/aes_ctr_sched.md
AES_CTR_SCHED -- requirements
Module: aes_ctr_sched

Interface
REQ-001 SHALL have parameter ROUNDS, default 10, AES rounds; the pipeline has ROUNDS+1 stages.
REQ-002 SHALL have parameter PIPE_LAT, default 12, cycles from pipe_next to the matching pipe_ready.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, output buffer entries; must be a power of 2 and greater than PIPE_LAT.
REQ-004 SHALL have ports, clock and reset first, as listed below; reset reset_n is asynchronous, active-low; clock is clk.
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- rk_we  in  1  round-key write strobe
- rk_idx  in  4  round-key index, 0..ROUNDS
- rk_data  in  128  round-key value
- start  in  1  begin stream (pulse)
- stop  in  1  abort stream (pulse)
- nonce  in  96  upper 96 counter-block bits, sampled on start
- ctr_init  in  32  initial counter value, sampled on start
- nblocks  in  32  blocks to generate; 0 means unbounded
- pipe_round  in  4  pipeline round counter
- pipe_round_key  out  128  key for pipe_round
- pipe_block  out  128  counter block to the pipeline
- pipe_next  out  1  issue strobe
- pipe_ready  in  1  result valid
- pipe_new_block  in  128  result
- out_valid  out  1  keystream valid
- out_ready  in  1  consumer accept
- out_data  out  128  keystream word
- busy  out  1  state is not IDLE
- done  out  1  one-cycle end-of-stream pulse
- err  out  1  counter-wrap error, sticky (macro only)

Function
REQ-005 SHALL hold ROUNDS+1 round keys in a register file. pipe_round_key SHALL be combinational rk[pipe_round]; an index above ROUNDS SHALL read 0.
REQ-006 rk_we SHALL write rk[rk_idx] in IDLE only. When busy the write SHALL be ignored.
REQ-007 The FSM SHALL have states IDLE, RUN and DRAIN.
- IDLE->RUN on start.
- RUN->DRAIN when the remaining count reaches 0 after an issue, or on stop.
- DRAIN->IDLE when the in-flight count is 0, the FIFO is empty, and out_valid is low.
REQ-008 On start, ctr SHALL load ctr_init, rem SHALL load nblocks, and the unbounded flag SHALL be set when nblocks==0.
REQ-009 In RUN, pipe_next SHALL be asserted when (inflight + fifo_count) < FIFO_DEPTH and (unbounded or rem>0).
REQ-010 pipe_block SHALL be {nonce_reg, ctr} in the pipe_next cycle. On issue, ctr SHALL increment modulo 2^32 and rem SHALL decrement (rem only when bounded).
REQ-011 inflight SHALL increment on pipe_next and decrement on pipe_ready; the net change is 0 when both occur in the same cycle. inflight SHALL never exceed FIFO_DEPTH.
REQ-012 On pipe_ready, pipe_new_block SHALL be written to the FIFO. Overflow is impossible by REQ-009, so no FIFO-full check is made on this write.
REQ-013 out_valid SHALL be asserted whenever the FIFO is non-empty, and out_data SHALL be the head entry.
- A pop occurs when out_valid && out_ready.
- A simultaneous push and pop SHALL leave the count unchanged.
- Output order SHALL equal issue order.
REQ-014 stop in RUN SHALL suppress pipe_next from the next cycle. Blocks already in flight SHALL still drain to the output.
REQ-015 stop in IDLE or DRAIN SHALL be ignored. start while busy SHALL be ignored.
REQ-016 done SHALL pulse for one cycle on the DRAIN->IDLE transition.
REQ-017 start and stop asserted in the same IDLE cycle: start SHALL win.

Reset
REQ-018 Asserting reset_n low SHALL immediately set:
- state to IDLE;
- pipe_next, out_valid, busy, done and err to 0;
- ctr, rem and inflight to 0;
- FIFO pointers to 0.
REQ-019 Round keys SHALL reset to 0.
REQ-020 Reset mid-stream SHALL discard all in-flight and buffered blocks. pipe_ready pulses arriving after reset release and while in IDLE SHALL be dropped and SHALL NOT underflow inflight.

Configuration
REQ-021 With AES_SCHED_WRAP_ERR_EN defined:
- an issue with ctr==32'hFFFFFFFF SHALL be the last issue;
- err SHALL be set and stay sticky until the next start;
- the FSM SHALL go to DRAIN.
Without the macro, ctr SHALL wrap silently to 0 and err SHALL be tied to 0.

Structure
REQ-022 Package aes_sched_pkg SHALL hold the FSM state enum, counter width (32), block width (128) and key-index width (4).
REQ-023 The FIFO SHALL be sub-module aes_sched_fifo, a synchronous first-word fall-through FIFO with FIFO_DEPTH and count output.

Verification
REQ-024 Load FIPS-197 key 000102..0f schedule; start, nblocks=1, nonce=0, ctr_init=0 -> one out word = AES_k(0), then done pulse; busy low.
REQ-025 nblocks=40, out_ready held 1 -> 40 words, counters 0..39, in order. After fill, pipe_next is high every cycle.
REQ-026 nblocks=0, out_ready=0 -> exactly FIFO_DEPTH pipe_next pulses, then none; release out_ready -> issues resume at 1 per pop.
REQ-027 ctr_init=32'hFFFFFFFE, nblocks=4 -> with macro: 2 words, err=1. Without macro: counters FFFFFFFE, FFFFFFFF, 0, 1.
REQ-028 stop 5 cycles after start -> 5 words delivered, then done; rk_we during busy leaves the keys unchanged.
REQ-029 reset_n low with inflight=8 -> outputs 0 at once; late pipe_ready pulses dropped; a following start works normally.
